roi_frame_pingpong_ctrl: RTL

- Sits between the 28x28 ROI downsampler and the CNN inference engine.
- Owns a double-buffered ROI RAM (2 x 784 bytes) and decides which bank each incoming ROI frame is written into.
- Discards incomplete or malformed frames.
- Hands completed banks to the CNN through a take/done handshake, so capture and inference overlap without tearing.

---
 rtl/roi_frame_pingpong_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/roi_frame_pingpong_ctrl.sv
// rtl/roi_frame_pingpong_ctrl.sv - double-buffered ROI RAM bank manager between downsampler and CNN
// Writer FSM fills the lowest FREE bank; completed banks are offered oldest-first through take/done.
module roi_frame_pingpong_ctrl #(
    parameter int ROI_PIX = 784,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              single_shot,
    input  logic              sof,
    input  logic              roi_we,
    input  logic [ADDR_W-1:0] roi_addr,
    input  logic [7:0]        roi_dout,
    input  logic              roi_frame_done,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [7:0]        ram_din,
    output logic              frm_valid,
    output logic              frm_bank,
    input  logic              frm_take,
    input  logic              frm_done,
    output logic              capturing,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam logic [ADDR_W:0] PIX_N = ROI_PIX[ADDR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_t;
    typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_READING} bank_t;

    state_t          state;
    bank_t           bank_st [2];
    logic            cur_bank;
    logic            newest;
    logic [ADDR_W:0] pix_cnt;
    logic            bad;

    logic            has_free;
    logic            free_sel;
    logic [1:0]      ready_v;
    logic [1:0]      reading_v;
    logic            oldest_ready;
    logic            take_ok;
    logic            addr_ok;
    logic [ADDR_W:0] cnt_inc;
    logic            good;

    assign has_free     = (bank_st[0] == B_FREE) || (bank_st[1] == B_FREE);
    assign free_sel     = (bank_st[0] == B_FREE) ? 1'b0 : 1'b1;
    assign ready_v      = {bank_st[1] == B_READY, bank_st[0] == B_READY};
    assign reading_v    = {bank_st[1] == B_READING, bank_st[0] == B_READING};
    // With both banks READY the older one is whichever did not complete last.
    assign oldest_ready = (&ready_v) ? ~newest : ready_v[1];
    assign take_ok      = frm_take && frm_valid;
    assign addr_ok      = {1'b0, roi_addr} < PIX_N;
    assign cnt_inc      = (roi_we && pix_cnt != '1) ? pix_cnt + {{ADDR_W{1'b0}}, 1'b1} : pix_cnt;
    assign good         = (cnt_inc == PIX_N) && !bad && !(roi_we && !addr_ok);
    assign capturing    = (state == S_CAP);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bank_st[0] <= B_FREE;
            bank_st[1] <= B_FREE;
            cur_bank   <= 1'b0;
            newest     <= 1'b0;
            pix_cnt    <= '0;
            bad        <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            frm_valid  <= 1'b0;
            frm_bank   <= 1'b0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                S_IDLE: if (enable) state <= S_ARM;
                S_ARM: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (sof) begin
                        if (has_free) begin
                            bank_st[free_sel] <= B_FILLING;
                            cur_bank          <= free_sel;
                            pix_cnt           <= '0;
                            bad               <= 1'b0;
                            state             <= S_CAP;
                        end else if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_CAP: begin
                    if (!enable) begin
                        bank_st[cur_bank] <= B_FREE;
                        state             <= S_IDLE;
                    end else if (sof) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        pix_cnt <= '0;
                        bad     <= 1'b0;
                    end else begin
                        if (roi_we && addr_ok) begin
                            ram_we   <= 1'b1;
                            ram_addr <= {cur_bank, roi_addr};
                            ram_din  <= roi_dout;
                        end
                        if (roi_we && !addr_ok) bad <= 1'b1;
                        pix_cnt <= cnt_inc;
                        if (roi_frame_done) begin
                            if (good) begin
                                bank_st[cur_bank] <= B_READY;
                                newest            <= cur_bank;
                                state             <= single_shot ? S_DONE : S_ARM;
                            end else begin
                                if (err_cnt != '1) err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                                bank_st[cur_bank] <= B_FREE;
                                state             <= S_ARM;
                            end
                        end
                    end
                end
                S_DONE: if (!enable) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Consumer transitions touch only READY/READING banks, never the FILLING one.
            if (take_ok) bank_st[frm_bank] <= B_READING;
            if (frm_done && |reading_v) bank_st[reading_v[1]] <= B_FREE;

            frm_valid <= |ready_v && !(|reading_v) && !take_ok;
            if (!take_ok) begin
                if (|reading_v && !frm_done) frm_bank <= reading_v[1];
                else if (|ready_v)           frm_bank <= oldest_ready;
            end
        end
    end
endmodule
